// File: rtl/pin_driver.sv
// pin_driver: drives one GPIO pad from a requested level and holds each driven
// level for at least HOLD_TICKS counted ena ticks. Push-pull or open-drain
// drive; in open-drain mode a released-high line that reads back low stretches
// the hold. A 1-deep pending slot accepts a new level while the current one is
// still being held.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   ena      tick strobe; hold counting advances only when ena=1
//   valid    level request strobe
//   din      requested level, qualified by valid
//   ready    request slot free; a transfer happens when valid && ready
//   pin_in   filtered/synchronised pad readback (used in open-drain mode only)
//   dout     pad output value
//   oe       pad output enable
//   busy     hold in progress or pending level stored
//   stretch  released-high line is being held low externally
module pin_driver #(
    parameter int unsigned HOLD_TICKS = 2,
    parameter int unsigned CW         = 4,
    parameter bit          OPEN_DRAIN = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic valid,
    input  logic din,
    output logic ready,
    input  logic pin_in,
    output logic dout,
    output logic oe,
    output logic busy,
    output logic stretch
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    // Counter value on which the final counted tick of a hold lands.
    localparam logic [CW-1:0] HoldLast = CW'(HOLD_TICKS - 1);

    state_e        state_q, state_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pend_q, pend_d;

    logic accept;
    logic line_low;
    logic tick;
    logic hold_end;
    logic src_vld;
    logic src_lvl;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            level_q    <= IDLE_LEVEL;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;

        accept   = valid & ~pend_vld_q;
        // Released-high line still reads low: someone else is holding it.
        line_low = OPEN_DRAIN & level_q & ~pin_in;
        tick     = (state_q == StHold) & ena & ~line_low;
        hold_end = tick & (cnt_q == HoldLast);
        // Pending level takes priority; otherwise a same-cycle request is
        // handed straight to the pad without a gap.
        src_vld  = pend_vld_q | accept;
        src_lvl  = pend_vld_q ? pend_q : din;

        unique case (state_q)
            StIdle: begin
                if (accept && (din != level_q)) begin
                    level_d = din;
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (hold_end) begin
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    if (src_vld && (src_lvl != level_q)) begin
                        level_d = src_lvl;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (tick) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (accept) begin
                        pend_vld_d = 1'b1;
                        pend_d     = din;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        ready   = ~pend_vld_q;
        busy    = (state_q == StHold) | pend_vld_q;
        stretch = line_low;
        if (OPEN_DRAIN) begin
            dout = 1'b0;
            oe   = ~level_q;
        end else begin
            dout = level_q;
            oe   = 1'b1;
        end
    end

endmodule

// File: tb/tb_pin_driver.sv
// Bench for pin_driver: a push-pull and an open-drain instance share stimulus
// and are each compared against a behavioural model every cycle.
module tb_pin_driver;

    localparam int unsigned HOLD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       valid = 1'b0;
    logic       din = 1'b0;
    logic       pin_in = 1'b1;
    logic [1:0] ready, dout, oe, busy, stretch;

    int checks = 0;
    int failures = 0;

    // Behavioural model, index 0 = push-pull, 1 = open-drain
    bit m_level[2];
    bit m_hold[2];
    int m_left[2];
    int m_pn[2];
    bit m_pend[2];

    pin_driver #(.HOLD_TICKS(HOLD), .CW(4), .OPEN_DRAIN(1'b0), .IDLE_LEVEL(1'b1)) u_pp (
        .clk(clk), .reset(reset), .ena(ena), .valid(valid), .din(din), .ready(ready[0]),
        .pin_in(pin_in), .dout(dout[0]), .oe(oe[0]), .busy(busy[0]), .stretch(stretch[0])
    );

    pin_driver #(.HOLD_TICKS(HOLD), .CW(4), .OPEN_DRAIN(1'b1), .IDLE_LEVEL(1'b1)) u_od (
        .clk(clk), .reset(reset), .ena(ena), .valid(valid), .din(din), .ready(ready[1]),
        .pin_in(pin_in), .dout(dout[1]), .oe(oe[1]), .busy(busy[1]), .stretch(stretch[1])
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_level[i] = 1'b1;
            m_hold[i]  = 1'b0;
            m_left[i]  = 0;
            m_pn[i]    = 0;
            m_pend[i]  = 1'b0;
        end
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_step();
        bit acc, st, have, nxt;
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                acc = valid && (m_pn[i] == 0);
                st  = (i == 1) && m_level[i] && !pin_in;
                if (!m_hold[i]) begin
                    if (acc && din != m_level[i]) begin
                        m_level[i] = din;
                        m_hold[i]  = 1'b1;
                        m_left[i]  = HOLD;
                    end
                end else begin
                    if (ena && !st) m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        have = (m_pn[i] != 0) || acc;
                        nxt  = (m_pn[i] != 0) ? m_pend[i] : din;
                        m_pn[i] = 0;
                        if (have && nxt != m_level[i]) begin
                            m_level[i] = nxt;
                            m_left[i]  = HOLD;
                        end else begin
                            m_hold[i] = 1'b0;
                        end
                    end else if (acc) begin
                        m_pend[i] = din;
                        m_pn[i]   = 1;
                    end
                end
            end
        end
    endfunction

    // {dout, oe, ready, busy, stretch}
    function automatic logic [4:0] exp_vec(int i);
        bit od;
        od = (i == 1);
        return {od ? 1'b0 : m_level[i], od ? !m_level[i] : 1'b1, m_pn[i] == 0,
                m_hold[i] || (m_pn[i] != 0), od && m_level[i] && !pin_in};
    endfunction

    function automatic logic [4:0] obs_vec(int i);
        return {dout[i], oe[i], ready[i], busy[i], stretch[i]};
    endfunction

    task automatic drive(input bit r, input bit v, input bit d, input bit e, input bit p);
        @(negedge clk);
        reset  = r;
        valid  = v;
        din    = d;
        ena    = e;
        pin_in = p;
        if (r) model_reset();
        #1;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 1);
        checks++;
        if (obs_vec(0) !== 5'b11100) begin
            failures++;
            $display("FAIL reset_pp: got %b want %b", obs_vec(0), 5'b11100);
        end
        checks++;
        if (obs_vec(1) !== 5'b00100) begin
            failures++;
            $display("FAIL reset_od: got %b want %b", obs_vec(1), 5'b00100);
        end
        advance();
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, k[0], 1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL reset_idle dut%0d k%0d: got %b want %b",
                             i, k, obs_vec(i), exp_vec(i));
                end
            end
            advance();
        end
    endtask

    task automatic test_hold_basic();
        for (int k = 0; k < 12; k++) begin
            drive(0, k == 0, 0, (k % 3) == 2, 1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL hold_basic dut%0d k%0d: got %b want %b",
                             i, k, obs_vec(i), exp_vec(i));
                end
            end
            if (k == 1) begin
                checks++;
                if (dout[0] !== 1'b0 || busy[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_basic_start: got dout=%b busy=%b want dout=0 busy=1",
                             dout[0], busy[0]);
                end
            end
            advance();
        end
        checks++;
        if (busy !== 2'b00) begin
            failures++;
            $display("FAIL hold_basic_end: got busy=%b want 00", busy);
        end
    endtask

    task automatic test_pending();
        bit sent2;
        bit v, d;
        sent2 = 1'b0;
        drive(1, 0, 0, 0, 1);
        advance();
        for (int k = 0; k < 24; k++) begin
            v = 1'b0;
            d = 1'b0;
            if (k == 0) begin
                v = 1'b1;
            end else if (k == 1) begin
                v = 1'b1;
                d = 1'b1;
            end else if (!sent2) begin
                v = 1'b1;
            end
            drive(0, v, d, k[0], 1);
            if (k >= 2 && !sent2 && m_pn[0] == 0) sent2 = 1'b1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL pending dut%0d k%0d: got %b want %b",
                             i, k, obs_vec(i), exp_vec(i));
                end
            end
            if (k == 2) begin
                checks++;
                if (ready[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL pending_stall: got ready=%b want 0", ready[0]);
                end
            end
            advance();
        end
    endtask

    task automatic test_stretch();
        bit v, d, e, p;
        drive(1, 0, 0, 0, 1);
        advance();
        for (int k = 0; k < 16; k++) begin
            v = (k == 0) || (k == 4);
            d = (k == 4);
            e = (k != 0) && (k != 4);
            p = (k >= 10);
            drive(0, v, d, e, p);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL stretch dut%0d k%0d: got %b want %b",
                             i, k, obs_vec(i), exp_vec(i));
                end
            end
            if (k >= 5 && k <= 9) begin
                checks++;
                if (stretch[1] !== 1'b1 || oe[1] !== 1'b0 || busy[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL stretch_hold k%0d: got stretch=%b oe=%b busy=%b want 1 0 1",
                             k, stretch[1], oe[1], busy[1]);
                end
            end
            if (k == 11) begin
                checks++;
                if (busy[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL stretch_release: got busy=%b want 1", busy[1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_same_level_handoff();
        bit v, d, e, handed;
        int hk;
        handed = 1'b0;
        hk = -10;
        drive(1, 0, 0, 0, 1);
        advance();
        for (int k = 0; k < 12; k++) begin
            v = 1'b0;
            d = 1'b0;
            e = (k >= 3);
            if (k == 0) begin
                v = 1'b1;
                d = 1'b1;
            end else if (k == 2) begin
                v = 1'b1;
            end else if (!handed && e && m_hold[0] && m_left[0] == 1) begin
                v = 1'b1;
                d = 1'b1;
                handed = 1'b1;
                hk = k;
            end
            drive(0, v, d, e, 1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL handoff dut%0d k%0d: got %b want %b",
                             i, k, obs_vec(i), exp_vec(i));
                end
            end
            if (k == 1) begin
                checks++;
                if (busy !== 2'b00 || dout[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL same_level: got busy=%b dout=%b want 00 1", busy, dout[0]);
                end
            end
            if (k == hk + 1) begin
                checks++;
                if (busy[0] !== 1'b1 || dout[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL handoff_gap: got busy=%b dout=%b want 1 1", busy[0], dout[0]);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_hold();
        drive(1, 0, 0, 0, 1);
        advance();
        drive(0, 1, 0, 0, 1);
        advance();
        drive(0, 1, 1, 0, 1);
        advance();
        // Async reset mid-hold with a stored pending level
        drive(1, 0, 0, 0, 1);
        checks++;
        if (dout[0] !== 1'b1 || oe[0] !== 1'b1 || oe[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_pad: got dout=%b oe=%b od_oe=%b want 1 1 0",
                     dout[0], oe[0], oe[1]);
        end
        advance();
        drive(0, 0, 0, 1, 1);
        checks++;
        if (ready !== 2'b11 || busy !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_after: got ready=%b busy=%b want 11 00", ready, busy);
        end
        advance();
    endtask

    task automatic test_random();
        bit r;
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 96) == 0);
            drive(r, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL random dut%0d k%0d: got %b want %b",
                             i, k, obs_vec(i), exp_vec(i));
                end
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold_basic();
        test_pending();
        test_stretch();
        test_same_level_handoff();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
